// File: rtl/instruction_fetch.sv
// Fetch stage: holds the program counter, runs the request/ready instruction fetch,
// and splits the latched instruction into the fields the controller and datapath use.
module instruction_fetch #(
    parameter int unsigned         ADDR_W   = 16,
    parameter int unsigned         INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               W_PC,
    input  logic               W_IM,
    input  logic               TAKEN,
    input  logic               S_TARGET,
    input  logic [ADDR_W-1:0]  RA_DATA,
    output logic [ADDR_W-1:0]  IM_ADDR,
    input  logic [INSTR_W-1:0] IM_DATA,
    input  logic               IM_RDY,
    output logic [ADDR_W-1:0]  PC,
    output logic [ADDR_W-1:0]  LINK_PC,
    output logic [2:0]         TYPE,
    output logic [4:0]         op,
    output logic [3:0]         RD,
    output logic [3:0]         RA,
    output logic [3:0]         RB,
    output logic [15:0]        IMM,
    output logic               IR_VALID,
    output logic               FETCH_ERR
);

    typedef enum logic {
        S_FREE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_d;
    logic [ADDR_W-1:0]  im_addr_q;
    logic [INSTR_W-1:0] ir_q;
    logic               ir_valid_q;
    logic               fetch_err_q;
    logic [ADDR_W-1:0]  imm_ext;

    // Branch offset: sign-extend IMM to the PC width, or truncate if PC is narrower
    if (ADDR_W > 16) begin : g_sext
        assign imm_ext = {{(ADDR_W-16){ir_q[15]}}, ir_q[15:0]};
    end else begin : g_trunc
        assign imm_ext = ir_q[ADDR_W-1:0];
    end

    // Next PC; arithmetic wraps modulo 2^ADDR_W
    always_comb begin
        pc_d = pc_q;
        if (W_PC) begin
            if (!TAKEN) begin
                pc_d = pc_q + ADDR_W'(1);
            end else if (S_TARGET) begin
                pc_d = RA_DATA;
            end else begin
                pc_d = pc_q + imm_ext;
            end
        end
    end

    // IM_ADDR only moves on FREE->WAIT, so PC writes never disturb an in-flight fetch
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_FREE;
            pc_q        <= RESET_PC;
            im_addr_q   <= RESET_PC;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                S_FREE: begin
                    if (W_IM) begin
                        im_addr_q  <= pc_q;
                        ir_valid_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (W_IM) begin
                        fetch_err_q <= 1'b1;
                    end
                    if (IM_RDY) begin
                        ir_q       <= IM_DATA;
                        ir_valid_q <= 1'b1;
                        state_q    <= S_FREE;
                    end
                end
                default: state_q <= S_FREE;
            endcase
        end
    end

    assign PC        = pc_q;
    assign LINK_PC   = pc_q + ADDR_W'(1);
    assign IM_ADDR   = im_addr_q;
    assign TYPE      = ir_q[31:29];
    assign op        = ir_q[28:24];
    assign RD        = ir_q[23:20];
    assign RA        = ir_q[19:16];
    assign RB        = ir_q[15:12];
    assign IMM       = ir_q[15:0];
    assign IR_VALID  = ir_valid_q;
    assign FETCH_ERR = fetch_err_q;

endmodule
